// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel dead-time PWM generator.
// Defaults match the motor-drive build: 11-bit period, two legs, 6-bit dead-time.
package pwm_pkg;

  localparam int PWM_WIDTH_DEF  = 11;
  localparam int PWM_NCH_DEF    = 2;
  localparam int PWM_DT_W_DEF   = 6;
  localparam int PWM_BUS_MAX    = 256;
  localparam int PWM_DUTY_MAX_W = 32;

  // Channel ch occupies bits [ch*width +: width] of the packed duty bus.
  function automatic logic [PWM_DUTY_MAX_W-1:0] pwm_chan_duty(
    input logic [PWM_BUS_MAX-1:0] bus,
    input int                     ch,
    input int                     width
  );
    logic [PWM_BUS_MAX-1:0]    shifted;
    logic [PWM_DUTY_MAX_W-1:0] mask;
    shifted = bus >> (ch * width);
    mask    = (width >= PWM_DUTY_MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
    return shifted[PWM_DUTY_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/pwm_deadband.sv
// One channel's dead-time inserter: turns the raw compare into a complementary
// high/low drive pair that is never high on both sides at once.
module pwm_deadband
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dead_time,
  output logic            PWM_sig,
  output logic            PWM_sig_n
);

  logic            lvl_q, lvl_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;

  // Settled state drives the side chosen by lvl; a raw change blanks both sides
  // for dead_time cycles, and a zero dead_time passes raw straight through.
  always_comb begin
    lvl_d    = lvl_q;
    dt_cnt_d = dt_cnt_q;
    hi_d     = lvl_q;
    lo_d     = ~lvl_q;
    if (!en) begin
      lvl_d    = 1'b0;
      dt_cnt_d = '0;
      hi_d     = 1'b0;
      lo_d     = 1'b0;
    end else if (raw != lvl_q) begin
      lvl_d = raw;
      if (dead_time == '0) begin
        dt_cnt_d = '0;
        hi_d     = raw;
        lo_d     = ~raw;
      end else begin
        dt_cnt_d = dead_time;
        hi_d     = 1'b0;
        lo_d     = 1'b0;
      end
    end else if (dt_cnt_q > DT_W'(1)) begin
      dt_cnt_d = dt_cnt_q - DT_W'(1);
      hi_d     = 1'b0;
      lo_d     = 1'b0;
    end else if (dt_cnt_q == DT_W'(1)) begin
      dt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q    <= 1'b0;
      dt_cnt_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      lvl_q    <= lvl_d;
      dt_cnt_q <= dt_cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign PWM_sig   = hi_q;
  assign PWM_sig_n = lo_q;

endmodule

// File: rtl/pwm_dt_multi.sv
// Multi-channel PWM with a shared period counter, double-buffered duty and
// per-channel dead-time insertion on complementary outputs.
module pwm_dt_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF,
  parameter int NCH   = PWM_NCH_DEF,
  parameter int DT_W  = PWM_DT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic [DT_W-1:0]      dead_time,
  output logic [NCH-1:0]       PWM_sig,
  output logic [NCH-1:0]       PWM_sig_n,
  output logic                 period_strt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_act_q [NCH];
  logic [WIDTH-1:0] duty_act_d [NCH];
  logic [WIDTH-1:0] duty_req   [NCH];
  logic [NCH-1:0]   raw;
  logic             wrap;

  assign wrap = (cnt_q == '1);

  // Shadow duty only moves at the wrap (or freely while disabled), so a period
  // always runs to completion with the duty it started with.
  always_comb begin
    cnt_d = en ? (cnt_q + WIDTH'(1)) : '0;
    for (int i = 0; i < NCH; i++) begin
      duty_act_d[i] = (!en || wrap) ? duty_req[i] : duty_act_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_act_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < NCH; i++) begin
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign period_strt = rst_n & en & (cnt_q == '0);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign duty_req[g] = WIDTH'(pwm_chan_duty(PWM_BUS_MAX'(duty), g, WIDTH));
    assign raw[g]      = (cnt_q < duty_act_q[g]);

    pwm_deadband #(
      .DT_W(DT_W)
    ) u_deadband (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .raw       (raw[g]),
      .dead_time (dead_time),
      .PWM_sig   (PWM_sig[g]),
      .PWM_sig_n (PWM_sig_n[g])
    );
  end

endmodule

// File: doc/pwm_dt_multi.md
# pwm_dt_multi

Multi-channel, parametrised PWM generator with complementary outputs, programmable dead-time and glitch-free double-buffered duty updates. It replaces the fixed 11-bit single-channel generator in the motor-drive path. Each channel drives one H-bridge leg pair through `PWM_sig`/`PWM_sig_n`. All channels share one period counter, so their edges are phase-aligned.

## Interface
- `WIDTH`, 11: counter and duty width. Period is 2^WIDTH clocks.
- `NCH`, 2: number of independent PWM channels.
- `DT_W`, 6: dead-time field width.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  generator enable.
- `duty`  in  NCH*WIDTH  packed requested duty; channel i is `duty[i*WIDTH +: WIDTH]`.
- `dead_time`  in  DT_W  number of cycles both outputs of a channel are held low around each transition. Shared by all channels.
- `PWM_sig`  out  NCH  high-side drive, per channel.
- `PWM_sig_n`  out  NCH  low-side drive, per channel.
- `period_strt`  out  1  high for exactly the cycle in which `cnt==0` and `en==1`.

## Operation
- `cnt`: WIDTH-bit free-running up-counter that wraps from 2^WIDTH-1 to 0.
- `duty_act[i]`: active (shadow) duty register per channel.
  - Loaded from `duty` on the edge where `cnt` wraps to 0.
  - Loaded continuously while `en==0`.
  - Never changes mid-period.
- Raw compare: `raw[i] = (cnt < duty_act[i])`, an unsigned WIDTH-bit compare.
  - Duty 0 gives 0% high.
  - Duty 2^WIDTH-1 gives (2^WIDTH-1)/2^WIDTH high.
  - 100% duty is not supported.
- Deadband stage, per channel. Registered state: `lvl`, `dt_cnt`, both outputs.
  - `dead_time==0`: outputs register `{raw, ~raw}` every edge.
  - `dead_time=D>0`, on an edge where `raw != lvl`:
    - `lvl <= raw`
    - both outputs <= 0
    - `dt_cnt <= D`
  - On subsequent edges:
    - If `dt_cnt>1`, decrement.
    - If `dt_cnt==1`, set `dt_cnt <= 0` and drive the output selected by `lvl` high; the other stays low.
  - If `raw` toggles again while `dt_cnt!=0`: update `lvl`, reload `dt_cnt <= D`, both outputs stay low.
  - `dead_time` is sampled on each load; changing it mid-deadband does not affect the current count.
- Invariant: `PWM_sig[i] & PWM_sig_n[i]` is never 1 on any cycle, for any D, including D=0.
- `en==0`, synchronously on the next edge:
  - `cnt` <= 0
  - all `dt_cnt` <= 0
  - all `lvl` <= 0
  - all outputs <= 0
  - `period_strt` is low
- `en` 0→1: the first enabled cycle has `cnt==0`, `period_strt==1`, and uses the `duty` value present at the enabling edge.

## Timing
- Reset (`rst_n==0` at an edge), on that edge:
  - `cnt` = 0
  - all `duty_act` = 0
  - all `lvl` = 0
  - all `dt_cnt` = 0
  - all `PWM_sig` = 0
  - all `PWM_sig_n` = 0
- `period_strt` is 0 while in reset.
- Reset mid-period or mid-deadband: the same values, on the same edge. No partial pulse completes.
- Compare-to-output latency is 1 clock: the outputs at cycle t reflect `raw` computed from `cnt` at t-1.
- The both-low window is exactly D cycles per transition when D>0 and the opposite level persists for at least D cycles.
- If a raw pulse is shorter than D cycles, the narrower side never asserts. There is no minimum-pulse stretching.
- A duty write becomes effective on the first `period_strt` after it has been stable across the wrap edge. Worst-case latency is 2^WIDTH cycles.
- Simultaneous wrap and `en` falling: `en` wins. Outputs go low and `duty_act` follows `duty`.

## Structure
- Shared package `pwm_pkg` holds:
  - default parameter constants (`PWM_WIDTH_DEF=11`, `PWM_NCH_DEF=2`, `PWM_DT_W_DEF=6`)
  - a helper that extracts channel i's duty from the packed bus.
- Sub-module `pwm_deadband`, instantiated NCH times via generate. One channel's state: `lvl`, `dt_cnt`, output registers.
  - Ports: `clk`, `rst_n`, `en`, `raw`, `dead_time`, `PWM_sig`, `PWM_sig_n`.
- The top level holds `cnt`, `duty_act[NCH]`, the compares and `period_strt`.

## Test plan
Defaults: WIDTH=11, NCH=2, `en=1`.
- Reset, duty ch0=0x000, D=0 → over 2048 cycles, `PWM_sig[0]` is never high and `PWM_sig_n[0]` is high for 2048 cycles. All outputs are 0 during reset.
- Duty ch0=0x400, ch1=0x200, D=0 → ch0 high for 1024 of 2048 cycles, ch1 high for 512. Both rise 1 cycle after `period_strt`.
- Duty ch0=0x400, D=5 → each period has exactly 5 cycles with both ch0 outputs low at each edge. `PWM_sig` is high for 1019 cycles. The assertion `PWM_sig&PWM_sig_n==0` never fires.
- Duty changed 0x400→0x100 at `cnt==300` → the current period keeps 1024 high. The next period, starting at `period_strt`, has 256 high.
- Duty ch0=0x003, D=5 → `PWM_sig[0]` never asserts. `PWM_sig_n[0]` re-asserts 5 cycles after `raw` falls.
- `rst_n` low at `cnt==700` mid-pulse, then `en` low/high → outputs go to 0 on that edge. Outputs are 0 while `en==0`. On re-enable, `period_strt` fires on the first enabled cycle with `cnt==0`.
